// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared opcode, instruction-field and state definitions for the ROM fetch sequencer.
package rom_fetch_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_STO = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;

  localparam int OPC_MSB  = 27;
  localparam int OPC_LSB  = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 16;
  localparam int SRCA_MSB = 15;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_MSB = 7;
  localparam int SRCB_LSB = 0;

  // One bit per opcode value: set when that opcode writes / reads registers.
  localparam logic [15:0] WRITER_MASK = (16'd1 << OP_STO) | (16'd1 << OP_ADD) | (16'd1 << OP_SUB);
  localparam logic [15:0] READER_MASK = (16'd1 << OP_ADD) | (16'd1 << OP_SUB);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DELAY = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  function automatic logic is_writer(input logic [3:0] op);
    return WRITER_MASK[op];
  endfunction

  function automatic logic is_reader(input logic [3:0] op);
    return READER_MASK[op];
  endfunction

endpackage

// File: rtl/rom_hazard_scoreboard.sv
// Shift-register scoreboard of recently issued destinations; flags a RAW match
// against either query source. Used only when FETCH_RAW_INTERLOCK_EN is defined.
module rom_hazard_scoreboard #(
  parameter int DEPTH = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       push,
  input  logic [7:0] destination,
  input  logic [7:0] srca,
  input  logic [7:0] srcb,
  output logic       hit
);

  logic [DEPTH-1:0] vld_r;
  logic [7:0]       dst_r [DEPTH];

  // Shift every cycle; a cycle without push inserts an invalid bubble entry.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_r <= '0;
      for (int i = 0; i < DEPTH; i++) dst_r[i] <= 8'd0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_r[i] <= vld_r[i-1];
        dst_r[i] <= dst_r[i-1];
      end
      vld_r[0] <= push;
      dst_r[0] <= destination;
    end
  end

  // Match any valid entry against either source operand.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_r[i] && ((dst_r[i] == srca) || (dst_r[i] == srcb))) hit = 1'b1;
      else hit = hit;
    end
  end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Program sequencer: owns the PC, issues ROM words through a valid/ready stage,
// absorbs NOPs as delays. Define FETCH_RAW_INTERLOCK_EN to enable RAW bubbles.
module rom_fetch_sequencer
  import rom_fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] PC_RESET     = 16'd0,
  parameter int          DELAY_WIDTH  = 24,
  parameter int          HAZARD_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iEnable,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iReady,
  output logic        oBusy
);

  state_e                 state_r, next_state_s;
  logic [15:0]            pc_r;
  logic [27:0]            instr_r;
  logic                   valid_r, busy_r;
  logic [DELAY_WIDTH-1:0] cnt_r;

  logic                   slot_free_s, accept_s, is_nop_s, nop_zero_s, hazard_s;
  logic                   pc_inc_s, load_s, clr_valid_s, cnt_load_s, cnt_dec_s;
  logic [3:0]             op_s;
  logic [DELAY_WIDTH-1:0] nop_cnt_s;

  assign op_s        = iInstruction[OPC_MSB:OPC_LSB];
  assign nop_cnt_s   = iInstruction[DELAY_WIDTH-1:0];
  assign is_nop_s    = (op_s == OP_NOP);
  assign nop_zero_s  = (nop_cnt_s == '0);
  assign slot_free_s = !valid_r || iReady;
  assign accept_s    = valid_r && iReady;

`ifdef FETCH_RAW_INTERLOCK_EN
  logic push_s, hit_s;

  assign push_s   = load_s && is_writer(op_s);
  assign hazard_s = is_reader(op_s) && hit_s;

  rom_hazard_scoreboard #(.DEPTH(HAZARD_DEPTH)) u_scoreboard (
    .Clock       (Clock),
    .Reset       (Reset),
    .push        (push_s),
    .destination (iInstruction[DST_MSB:DST_LSB]),
    .srca        (iInstruction[SRCA_MSB:SRCA_LSB]),
    .srcb        (iInstruction[SRCB_MSB:SRCB_LSB]),
    .hit         (hit_s)
  );
`else
  assign hazard_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  next_state_s = iEnable ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        if (!iEnable)                    next_state_s = ST_IDLE;
        else if (!slot_free_s)           next_state_s = ST_FETCH;
        else if (is_nop_s && !nop_zero_s) next_state_s = ST_DELAY;
        else if (!is_nop_s && hazard_s)  next_state_s = ST_STALL;
        else                             next_state_s = ST_FETCH;
      end
      ST_DELAY: next_state_s = (cnt_r == DELAY_WIDTH'(1)) ? ST_FETCH : ST_DELAY;
      ST_STALL: next_state_s = hazard_s ? ST_STALL : ST_FETCH;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    pc_inc_s    = 1'b0;
    load_s      = 1'b0;
    clr_valid_s = accept_s;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (!iEnable || !slot_free_s) begin
          clr_valid_s = accept_s;
        end else if (is_nop_s) begin
          pc_inc_s    = 1'b1;
          clr_valid_s = 1'b1;
          cnt_load_s  = !nop_zero_s;
        end else if (hazard_s) begin
          clr_valid_s = 1'b1;
        end else begin
          load_s   = 1'b1;
          pc_inc_s = 1'b1;
        end
      end
      ST_DELAY: cnt_dec_s = 1'b1;
      default:  cnt_dec_s = 1'b0;
    endcase
  end

  // PC, output stage, delay counter and busy flag.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_r    <= PC_RESET;
      instr_r <= 28'd0;
      valid_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      if (pc_inc_s) pc_r <= pc_r + 16'd1;
      if (load_s) begin
        instr_r <= iInstruction;
        valid_r <= 1'b1;
      end else if (clr_valid_s) begin
        valid_r <= 1'b0;
      end
      if (cnt_load_s)     cnt_r <= nop_cnt_s;
      else if (cnt_dec_s) cnt_r <= cnt_r - DELAY_WIDTH'(1);
      busy_r <= (next_state_s == ST_DELAY) || (next_state_s == ST_STALL);
    end
  end

  assign oAddress     = pc_r;
  assign oInstruction = instr_r;
  assign oValid       = valid_r;
  assign oBusy        = busy_r;

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for rom_fetch_sequencer with a behavioural ROM; a second
// instance reset near the top of the address space exercises PC wrap.
module tb_rom_fetch_sequencer;
  import rom_fetch_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset, iEnable, iReady, en_wrap;
  logic [15:0] oAddress, wrap_addr;
  logic [27:0] iInstruction, oInstruction, wrap_in, wrap_instr;
  logic        oValid, oBusy, wrap_valid, wrap_busy;
  logic [27:0] rom_mem [65536];
  int          errors = 0;
  int          checks = 0;

  always #5 Clock = ~Clock;

  always_comb iInstruction = rom_mem[oAddress];
  always_comb wrap_in      = rom_mem[wrap_addr];

  rom_fetch_sequencer dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .oAddress(oAddress),
    .iInstruction(iInstruction), .oInstruction(oInstruction), .oValid(oValid),
    .iReady(iReady), .oBusy(oBusy)
  );

  rom_fetch_sequencer #(.PC_RESET(16'hFFFE)) u_wrap (
    .Clock(Clock), .Reset(Reset), .iEnable(en_wrap), .oAddress(wrap_addr),
    .iInstruction(wrap_in), .oInstruction(wrap_instr), .oValid(wrap_valid),
    .iReady(iReady), .oBusy(wrap_busy)
  );

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1; iEnable = 1'b0; iReady = 1'b1; en_wrap = 1'b0;
    step(); step();
    checks++; if (oAddress !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0000", oAddress); end
    checks++; if (oValid !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0", oValid, oBusy); end
    checks++; if (oInstruction !== 28'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", oInstruction); end
    checks++; if (wrap_addr !== 16'hFFFE) begin errors++; $display("FAIL reset_pc_param: got %h expected fffe", wrap_addr); end
    Reset = 1'b0;
  endtask

  task automatic test_nop_delay();
    iEnable = 1'b1;
    step();
    checks++; if (oAddress !== 16'd0 || oValid !== 1'b0) begin errors++; $display("FAIL nop_fetch: got addr=%h valid=%b expected 0000 0", oAddress, oValid); end
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (oValid !== 1'b0 || oAddress !== 16'd1 || oBusy !== (c <= 3)) begin
        errors++;
        $display("FAIL nop_delay c%0d: got valid=%b addr=%h busy=%b expected 0 0001 %b", c, oValid, oAddress, oBusy, (c <= 3));
      end
    end
  endtask

  task automatic test_sto_stream();
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (oValid !== 1'b1 || oInstruction !== rom_mem[k] || oAddress !== 16'(k + 1)) begin
        errors++;
        $display("FAIL sto_stream k%0d: got valid=%b instr=%h addr=%h expected 1 %h %h", k, oValid, oInstruction, oAddress, rom_mem[k], 16'(k + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    iReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (oValid !== 1'b1 || oInstruction !== rom_mem[6] || oAddress !== 16'd7) begin
        errors++;
        $display("FAIL hold c%0d: got valid=%b instr=%h addr=%h expected 1 %h 0007", c, oValid, oInstruction, oAddress, rom_mem[6]);
      end
    end
    iReady = 1'b1;
    for (int k = 7; k <= 8; k++) begin
      step();
      checks++;
      if (oValid !== 1'b1 || oInstruction !== rom_mem[k] || oAddress !== 16'(k + 1)) begin
        errors++;
        $display("FAIL release k%0d: got valid=%b instr=%h addr=%h expected 1 %h %h", k, oValid, oInstruction, oAddress, rom_mem[k], 16'(k + 1));
      end
    end
  endtask

  task automatic test_hazard();
    int gap = 0;
    int busy_n = 0;
    int exp_gap, exp_busy;
    logic done = 1'b0;
`ifdef FETCH_RAW_INTERLOCK_EN
    exp_gap = 3; exp_busy = 2;
`else
    exp_gap = 0; exp_busy = 0;
`endif
    step();
    checks++; if (oValid !== 1'b1 || oInstruction !== rom_mem[9]) begin errors++; $display("FAIL hazard_add: got valid=%b instr=%h expected 1 %h", oValid, oInstruction, rom_mem[9]); end
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (oValid === 1'b1) done = 1'b1;
      else begin
        gap++;
        if (oBusy === 1'b1) busy_n++;
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hazard_timeout: got no issue expected issue within 10 cycles"); end
    checks++; if (oInstruction !== rom_mem[10] || oAddress !== 16'd11) begin errors++; $display("FAIL hazard_sub: got instr=%h addr=%h expected %h 000b", oInstruction, oAddress, rom_mem[10]); end
    checks++; if (gap !== exp_gap) begin errors++; $display("FAIL hazard_gap: got %0d expected %0d", gap, exp_gap); end
    checks++; if (busy_n !== exp_busy) begin errors++; $display("FAIL hazard_busy: got %0d expected %0d", busy_n, exp_busy); end
  endtask

  task automatic test_reset_mid_delay();
    step();
    checks++; if (oBusy !== 1'b1 || oValid !== 1'b0 || oAddress !== 16'd12) begin errors++; $display("FAIL long_delay: got busy=%b valid=%b addr=%h expected 1 0 000c", oBusy, oValid, oAddress); end
    Reset = 1'b1;
    step();
    checks++; if (oAddress !== 16'd0 || oValid !== 1'b0 || oBusy !== 1'b0) begin errors++; $display("FAIL mid_delay_reset: got addr=%h valid=%b busy=%b expected 0000 0 0", oAddress, oValid, oBusy); end
    Reset = 1'b0; iEnable = 1'b0;
  endtask

  task automatic test_pc_wrap();
    en_wrap = 1'b1;
    step();
    checks++; if (wrap_addr !== 16'hFFFE || wrap_valid !== 1'b0) begin errors++; $display("FAIL wrap_fetch: got addr=%h valid=%b expected fffe 0", wrap_addr, wrap_valid); end
    step();
    checks++; if (wrap_addr !== 16'hFFFF || wrap_valid !== 1'b0 || wrap_busy !== 1'b0) begin errors++; $display("FAIL nop_zero: got addr=%h valid=%b busy=%b expected ffff 0 0", wrap_addr, wrap_valid, wrap_busy); end
    step();
    checks++; if (wrap_addr !== 16'h0000 || wrap_valid !== 1'b1 || wrap_instr !== rom_mem[16'hFFFF]) begin errors++; $display("FAIL pc_wrap: got addr=%h valid=%b instr=%h expected 0000 1 %h", wrap_addr, wrap_valid, wrap_instr, rom_mem[16'hFFFF]); end
    checks++; if (oAddress !== 16'd0 || oValid !== 1'b0) begin errors++; $display("FAIL paused: got addr=%h valid=%b expected 0000 0", oAddress, oValid); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom_mem[a] = 28'd0;
    rom_mem[0] = {OP_NOP, 24'd3};
    for (int k = 1; k <= 8; k++) rom_mem[k] = {OP_STO, 8'(k + 16), 16'h1000 + 16'(k)};
    rom_mem[9]  = {OP_ADD, 8'd0, 8'd1, 8'd2};
    rom_mem[10] = {OP_SUB, 8'd4, 8'd0, 8'd6};
    rom_mem[11] = {OP_NOP, 24'd2000};
    rom_mem[16'hFFFE] = {OP_NOP, 24'd0};
    rom_mem[16'hFFFF] = {OP_STO, 8'd9, 16'hBEEF};
    test_reset();
    test_nop_delay();
    test_sto_stream();
    test_backpressure();
    test_hazard();
    test_reset_mid_delay();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
